// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a FIFO and its reader.
// The FIFO side (master) supplies registered data and the empty flag.
// The reader side (slave) returns the one-cycle pop strobe.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_empty_in;
  logic                  fifo_read_en_out;

  modport master (
    output fifo_data_in,
    output fifo_empty_in,
    input  fifo_read_en_out
  );

  modport slave (
    input  fifo_data_in,
    input  fifo_empty_in,
    output fifo_read_en_out
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter.
// Pops one word per frame from an upstream FIFO and sends it as
// start bit, DATA_WIDTH data bits LSB first, then STOP_BITS stop bits.
// Sequence per frame: IDLE -> POP (strobe) -> LATCH (capture data)
// -> START -> DATA -> STOP -> IDLE. The line output is registered so the
// serial pin never glitches; it goes low on the cycle after LATCH.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_in,
  fifo_uart_tx_if.slave   fifo,
  output logic            tx_out,
  output logic            busy_out,
  output logic            done_out
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 0) ? $clog2(DATA_WIDTH + 1) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]            r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_rd_en;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_baud_last;

  assign w_shift_nxt = r_shift >> 1;
  assign w_baud_last = (r_baud == BAUD_LAST);

  assign fifo.fifo_read_en_out = r_rd_en;
  assign tx_out                = r_tx;
  assign busy_out              = (r_state != S_IDLE);
  assign done_out              = r_done;

  // Frame sequencer: state, baud/bit counters, shift register and registered outputs.
  // The bit counter indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (enable_in && !fifo.fifo_empty_in) begin
            r_state <= S_POP;
            r_rd_en <= 1'b1;
          end
        end
        S_POP: begin
          // FIFO presents the popped word after this edge.
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_shift <= fifo.fifo_data_in;
          r_baud  <= '0;
          r_tx    <= 1'b0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shift <= w_shift_nxt;
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= w_shift_nxt[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          // Raise done for exactly the final cycle of the last stop bit.
          r_done <= (r_baud == BAUD_PRE) && (r_bit == STOP_LAST);
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances sharing one clock,
// A with CLKS_PER_BIT=4/STOP_BITS=1, B with CLKS_PER_BIT=4/STOP_BITS=2.
// Each is fed by a small registered-output FIFO model.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable_a = 1'b0;
  logic enable_b = 1'b0;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  int n_chk = 0;
  int n_err = 0;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) if_a ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) if_b ();

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_a), .fifo(if_a),
    .tx_out(tx_a), .busy_out(busy_a), .done_out(done_a)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_b), .fifo(if_b),
    .tx_out(tx_b), .busy_out(busy_b), .done_out(done_b)
  );

  always #5 clk = ~clk;

  // FIFO models: registered data_out updated on the edge that sees the pop.
  logic [7:0] mem_a [0:15];
  logic [7:0] mem_b [0:15];
  int push_a = 0, pop_a = 0, rd_cnt_a = 0;
  int push_b = 0, pop_b = 0, rd_cnt_b = 0;

  assign if_a.fifo_empty_in = (push_a == pop_a);
  assign if_b.fifo_empty_in = (push_b == pop_b);

  always @(posedge clk) begin
    if (if_a.fifo_read_en_out === 1'b1) begin
      if_a.fifo_data_in <= mem_a[pop_a];
      pop_a    <= pop_a + 1;
      rd_cnt_a <= rd_cnt_a + 1;
    end
  end

  always @(posedge clk) begin
    if (if_b.fifo_read_en_out === 1'b1) begin
      if_b.fifo_data_in <= mem_b[pop_b];
      pop_b    <= pop_b + 1;
      rd_cnt_b <= rd_cnt_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word_a(input logic [7:0] w);
    mem_a[push_a] = w;
    push_a++;
  endtask

  // Expected line level per cycle (bit c = frame cycle c+1), 4 clocks per bit.
  function automatic logic [63:0] exp_line(input logic [7:0] w, input int stops);
    logic [63:0] v;
    int slot;
    v = '1;
    for (int c = 0; c < (1 + 8 + stops) * 4; c++) begin
      slot = c / 4;
      if (slot == 0) v[c] = 1'b0;
      else if (slot <= 8) v[c] = w[slot-1];
      else v[c] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic cur_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  // Wait (bounded) for the start-bit fall, then record len cycles of the line.
  task automatic capture(input bit sel, input int len, output logic [63:0] line,
                         output int hi_before, output int done_at, output int done_n);
    bit found;
    found = 1'b0;
    hi_before = 0;
    line = '1;
    done_at = 0;
    done_n = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cur_tx(sel) === 1'b0) found = 1'b1;
      else hi_before++;
    end
    chk("frame_start_seen", 64'(found), 64'd1);
    if (found) begin
      for (int c = 0; c < len; c++) begin
        if (c > 0) @(negedge clk);
        line[c] = cur_tx(sel);
        if (cur_done(sel) === 1'b1) begin
          done_n++;
          done_at = c + 1;
        end
      end
    end
  endtask

  logic [63:0] line;
  int hi, dat, dn, rd0;
  bit fall_seen;

  initial begin
    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_a",   64'(tx_a),   64'd1);
    chk("rst_rd_a",   64'(if_a.fifo_read_en_out), 64'd0);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_tx_b",   64'(tx_b),   64'd1);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enable_a = 1'b1;
    enable_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_empty_no_pop", 64'(rd_cnt_a), 64'd0);

    // Single frame 0xA5: pop on cycle 1, line low on cycle 3 after the sample edge.
    push_word_a(8'hA5);
    @(negedge clk);
    chk("lat_c1_rd", 64'(if_a.fifo_read_en_out), 64'd1);
    chk("lat_c1_tx", 64'(tx_a), 64'd1);
    @(negedge clk);
    chk("lat_c2_rd", 64'(if_a.fifo_read_en_out), 64'd0);
    chk("lat_c2_tx", 64'(tx_a), 64'd1);
    capture(1'b0, 40, line, hi, dat, dn);
    chk("lat_c3_fall", 64'(hi), 64'd0);
    chk("a5_line", line, exp_line(8'hA5, 1));
    chk("a5_done_at", 64'(dat), 64'd40);
    chk("a5_done_n", 64'(dn), 64'd1);
    chk("a5_busy_last", 64'(busy_a), 64'd1);
    @(negedge clk);
    chk("a5_busy_after", 64'(busy_a), 64'd0);
    chk("a5_done_after", 64'(done_a), 64'd0);
    chk("a5_one_pop", 64'(rd_cnt_a), 64'd1);

    // Back-to-back 0x00, 0xFF, 0x3C.
    enable_a = 1'b0;
    push_word_a(8'h00);
    push_word_a(8'hFF);
    push_word_a(8'h3C);
    @(negedge clk);
    enable_a = 1'b1;
    capture(1'b0, 40, line, hi, dat, dn);
    chk("b2b0_line", line, exp_line(8'h00, 1));
    chk("b2b0_done_at", 64'(dat), 64'd40);
    capture(1'b0, 40, line, hi, dat, dn);
    chk("b2b1_gap", 64'(hi + 4), 64'd7);
    chk("b2b1_line", line, exp_line(8'hFF, 1));
    capture(1'b0, 40, line, hi, dat, dn);
    chk("b2b2_gap", 64'(hi + 4), 64'd7);
    chk("b2b2_line", line, exp_line(8'h3C, 1));
    chk("b2b2_done_at", 64'(dat), 64'd40);
    repeat (10) @(negedge clk);
    chk("b2b_pops", 64'(rd_cnt_a), 64'd4);
    chk("b2b_empty", 64'(if_a.fifo_empty_in), 64'd1);
    chk("b2b_idle_tx", 64'(tx_a), 64'd1);
    chk("b2b_idle_busy", 64'(busy_a), 64'd0);

    // Enable gating: drop enable during data bits of the first of two words.
    push_word_a(8'h11);
    push_word_a(8'h22);
    fork
      capture(1'b0, 40, line, hi, dat, dn);
      begin
        repeat (12) @(negedge clk);
        enable_a = 1'b0;
      end
    join
    chk("gate_line", line, exp_line(8'h11, 1));
    chk("gate_done_at", 64'(dat), 64'd40);
    chk("gate_done_n", 64'(dn), 64'd1);
    repeat (20) @(negedge clk);
    chk("gate_no_pop", 64'(rd_cnt_a), 64'd5);
    chk("gate_busy", 64'(busy_a), 64'd0);
    chk("gate_not_empty", 64'(if_a.fifo_empty_in), 64'd0);
    enable_a = 1'b1;
    @(negedge clk);
    chk("gate_pop_next", 64'(if_a.fifo_read_en_out), 64'd1);
    capture(1'b0, 40, line, hi, dat, dn);
    chk("gate2_line", line, exp_line(8'h22, 1));
    chk("gate2_done_at", 64'(dat), 64'd40);
    repeat (4) @(negedge clk);

    // Reset mid-frame during data bit 3 of 0x5A, then 0xC3 must go out intact.
    push_word_a(8'h5A);
    push_word_a(8'hC3);
    fall_seen = 1'b0;
    for (int i = 0; i < 50 && !fall_seen; i++) begin
      @(negedge clk);
      if (tx_a === 1'b0) fall_seen = 1'b1;
    end
    chk("rstmid_fall", 64'(fall_seen), 64'd1);
    repeat (13) @(negedge clk);
    chk("rstmid_bit2", 64'(tx_a), 64'd0);
    repeat (4) @(negedge clk);
    chk("rstmid_bit3", 64'(tx_a), 64'd1);
    chk("rstmid_busy_pre", 64'(busy_a), 64'd1);
    rd0 = rd_cnt_a;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_tx", 64'(tx_a), 64'd1);
    chk("rstmid_busy", 64'(busy_a), 64'd0);
    chk("rstmid_rd", 64'(if_a.fifo_read_en_out), 64'd0);
    chk("rstmid_done", 64'(done_a), 64'd0);
    @(negedge clk);
    chk("rstmid_hold_rd", 64'(rd_cnt_a - rd0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrel_first_pop", 64'(if_a.fifo_read_en_out), 64'd1);
    capture(1'b0, 40, line, hi, dat, dn);
    chk("rstrel_line", line, exp_line(8'hC3, 1));
    chk("rstrel_done_at", 64'(dat), 64'd40);
    chk("rstrel_done_n", 64'(dn), 64'd1);
    chk("rstrel_pops", 64'(rd_cnt_a - rd0), 64'd1);

    // Two stop bits on instance B: 0x81, 44-cycle frame.
    mem_b[push_b] = 8'h81;
    push_b++;
    capture(1'b1, 44, line, hi, dat, dn);
    chk("s2_line", line, exp_line(8'h81, 2));
    chk("s2_done_at", 64'(dat), 64'd44);
    chk("s2_done_n", 64'(dn), 64'd1);
    @(negedge clk);
    chk("s2_busy_after", 64'(busy_b), 64'd0);
    chk("s2_pops", 64'(rd_cnt_b), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Reader-side consumer for the team's FIFO read port.
- Pops one word at a time from an upstream FIFO (registered data_out, empty flag, read enable) and serialises it on a UART TX line: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
- Sits between the CPU-side TX FIFO and the board serial pin, entirely in the FIFO's read-clock domain.

Parameters:
- DATA_WIDTH, 8, word width popped from FIFO and bits per frame.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  single clock, also drives the FIFO read port.
- rst_n  input  1  asynchronous active-low reset.
- enable_in  input  1  permits starting new frames; does not abort a frame in progress.
- fifo_data_in  input  DATA_WIDTH  FIFO data output; valid on the cycle after a pop.
- fifo_empty_in  input  1  FIFO empty flag.
- fifo_read_en_out  output  1  FIFO pop strobe, registered, high exactly one cycle per frame.
- tx_out  output  1  serial line, idle high.
- busy_out  output  1  high whenever state ≠ IDLE.
- done_out  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (asynchronous, no clock needed):
  - state=IDLE, tx_out=1, fifo_read_en_out=0, busy_out=0, done_out=0.
  - Bit counter and baud counter cleared; shift register cleared.
- States: IDLE, POP, LATCH, START, DATA, STOP.
- IDLE:
  - tx_out=1.
  - If enable_in=1 and fifo_empty_in=0 at a rising edge, go to POP and set fifo_read_en_out=1 for the POP cycle only.
  - Otherwise remain in IDLE.
- POP: one cycle. The FIFO updates its data_out at the edge ending POP. Go to LATCH; fifo_read_en_out returns to 0.
- LATCH: one cycle.
  - Capture fifo_data_in into the shift register.
  - Go to START; tx_out=0 from the next cycle.
- START: tx_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_out = shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - After DATA_WIDTH bits, go to STOP.
- STOP:
  - tx_out=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - done_out=1 on the final cycle, then go to IDLE.
  - STOP never returns directly to POP.
- Timing:
  - Frame length on the line from the start-bit fall to the end of the stop bits = (1+DATA_WIDTH+STOP_BITS)×CLKS_PER_BIT cycles.
  - Minimum idle-high gap between back-to-back frames = STOP_BITS×CLKS_PER_BIT + 3 cycles (stop bits plus IDLE, POP, LATCH).
- Latency: tx_out falls 3 cycles after the edge at which IDLE samples enable_in=1 and fifo_empty_in=0.
- Counters:
  - Baud counter width = clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index width = clog2(DATA_WIDTH+1).
  - No counter may overflow at maximum parameter values.
- fifo_empty_in is sampled only in IDLE. A FIFO that becomes empty mid-frame has no effect on the current frame.
- enable_in is sampled only in IDLE. Deasserting it mid-frame lets the frame finish normally; no further pops follow.
- Exactly one pop per frame. fifo_read_en_out is never asserted while fifo_empty_in=1 was sampled.
- Reset mid-frame:
  - Line returns high immediately.
  - The popped word is discarded.
  - No pop or done_out occurs until a fresh IDLE→POP after reset release.
- Reset release: first possible pop is at the first rising edge with rst_n=1.

Test Plan:
- Reset check: assert rst_n=0 between clock edges → tx_out=1, fifo_read_en_out=0, busy_out=0, done_out=0 immediately, before any clock edge.
- Single frame, CLKS_PER_BIT=4, STOP_BITS=1, FIFO holds 0xA5, enable_in=1:
  - Exactly one read_en pulse.
  - tx_out falls 3 cycles after the IDLE sample.
  - Line carries 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles; frame is 40 cycles.
  - done_out pulses once, on cycle 40 of the frame.
  - busy_out falls the cycle after done_out.
- Back-to-back, FIFO holds 0x00, 0xFF, 0x3C:
  - Three pops, three frames with correct bits.
  - Line high for exactly 4+3=7 cycles between frames.
  - No pop after the third frame; fifo_empty_in=1 is then sampled.
- Enable gating: drop enable_in during the DATA bits of the first of two queued words → first frame completes with done_out; no second pop while enable_in=0. Raise enable_in → second pop the next IDLE cycle; second frame is correct.
- Reset mid-frame: pulse rst_n low during data bit 3 of 0x5A → tx_out=1 immediately and the frame is aborted. After release, the next FIFO word (0xC3) is sent as a complete, correct frame.
- STOP_BITS=2, CLKS_PER_BIT=4, word 0x81 → stop level held 8 cycles; frame is 44 cycles; done_out on cycle 44.
